// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: single-outstanding IMEM requests, predictor-steered next PC, 2-deep IF/ID buffer.
// Optional performance counters are built only when IFU_PERF_EN is defined.
module if_fetch_unit #(
  parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] bp_pc,
  input  logic        bp_taken,
  input  logic [31:0] bp_target,
  output logic        if_done,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_ptarget,
  output logic        id_ptaken,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt
);

  typedef enum logic [1:0] {FETCH, DROP, STALL} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] ptarget;
    logic        ptaken;
  } ent_t;

  state_t      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  ent_t        out_q, out_d, hold_q, hold_d;
  logic        out_vld_q, out_vld_d, hold_vld_q, hold_vld_d;

  ent_t        fetch_ent;
  logic [31:0] next_pc;
  logic        consume;

  assign im_req  = (state_q != STALL);
  assign im_addr = req_pc_q;
  assign bp_pc   = req_pc_q;
  assign if_done = (state_q == FETCH) && im_rvalid && !redirect_valid;

  assign id_valid   = out_vld_q;
  assign id_inst    = out_q.inst;
  assign id_pc      = out_q.pc;
  assign id_ptarget = out_q.ptarget;
  assign id_ptaken  = out_q.ptaken;

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    pend_pc_d  = pend_pc_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;

    fetch_ent.inst    = im_rdata;
    fetch_ent.pc      = req_pc_q;
    fetch_ent.ptarget = bp_target;
    fetch_ent.ptaken  = bp_taken;
    next_pc           = bp_taken ? bp_target : req_pc_q + 32'd4;
    consume           = out_vld_q && id_ready;

    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          out_vld_d = 1'b0;
          if (im_rvalid) begin
            req_pc_d = redirect_pc;
          end else begin
            pend_pc_d = redirect_pc;
            state_d   = DROP;
          end
        end else begin
          if (consume) out_vld_d = 1'b0;
          if (im_rvalid) begin
            req_pc_d = next_pc;
            if (!out_vld_q || id_ready) begin
              out_d     = fetch_ent;
              out_vld_d = 1'b1;
            end else begin
              hold_d     = fetch_ent;
              hold_vld_d = 1'b1;
              state_d    = STALL;
            end
          end
        end
      end
      // The in-flight request keeps its address; its response is thrown away.
      DROP: begin
        if (redirect_valid) pend_pc_d = redirect_pc;
        if (im_rvalid) begin
          req_pc_d = redirect_valid ? redirect_pc : pend_pc_q;
          state_d  = FETCH;
        end
      end
      STALL: begin
        if (redirect_valid) begin
          out_vld_d  = 1'b0;
          hold_vld_d = 1'b0;
          req_pc_d   = redirect_pc;
          state_d    = FETCH;
        end else if (id_ready) begin
          out_d      = hold_q;
          out_vld_d  = 1'b1;
          hold_vld_d = 1'b0;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      req_pc_q   <= BOOT_PC;
      pend_pc_q  <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      pend_pc_q  <= pend_pc_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d, perf_redir_q, perf_redir_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, if_done};
    perf_redir_d = perf_redir_q + {31'd0, redirect_valid};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_redir_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_redir_q <= perf_redir_d;
    end
  end

  assign perf_fetch_cnt    = perf_fetch_q;
  assign perf_redirect_cnt = perf_redir_q;
`else
  assign perf_fetch_cnt    = 32'h0;
  assign perf_redirect_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: randomized memory latency, backpressure, predictions and redirects
// checked every cycle against a queue-based model, plus directed literal scenarios.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req, im_rvalid, bp_taken, if_done, redirect_valid, id_valid, id_ready, id_ptaken;
  logic [31:0] im_addr, im_rdata, bp_pc, bp_target, redirect_pc;
  logic [31:0] id_inst, id_pc, id_ptarget, perf_fetch_cnt, perf_redirect_cnt;

  if_fetch_unit dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target), .if_done(if_done),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .id_ptarget(id_ptarget), .id_ptaken(id_ptaken),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
  } ent_t;

  int errors = 0;
  int checks = 0;

  // Model: IF/ID contents as a queue, the PC being requested, and a pending-redirect marker.
  ent_t        q[$];
  logic [31:0] exp_addr;
  bit          doomed;
  logic [31:0] doom_pc;
  logic [31:0] exp_fc, exp_rc;

  bit mem_busy;
  int wl;

  int knob_w, knob_rdy, knob_bt;
  bit knob_wrand, knob_rdrand;

  logic [31:0] addr_log[$], idpc_log[$], ptg_log[$], pf_log[$], pr_log[$];
  logic        req_log[$], done_log[$], vld_log[$], ptk_log[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] rnd_pc();
    logic [31:0] r;
    r = $urandom;
    return {r[31:2], 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete(); idpc_log.delete(); ptg_log.delete(); pf_log.delete(); pr_log.delete();
    req_log.delete(); done_log.delete(); vld_log.delete(); ptk_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    im_rvalid = 1'b0; im_rdata = '0; bp_taken = 1'b0; bp_target = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    mem_busy = 1'b0; wl = 0;
    q.delete(); exp_addr = 32'h0; doomed = 1'b0; doom_pc = '0; exp_fc = '0; exp_rc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_im_req", {31'd0, im_req}, 32'd1);
    chk("rst_im_addr", im_addr, 32'h0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_redir", perf_redirect_cnt, 32'h0);
  endtask

  task automatic cycle(input bit frd, input logic [31:0] fpc);
    bit          rv, rd, rdy, bt, req_on, exp_done, consume;
    logic [31:0] rd_pc, btgt;
    @(negedge clk);
    if (im_req && !mem_busy) begin
      mem_busy = 1'b1;
      wl = knob_wrand ? $urandom_range(0, knob_w) : knob_w;
    end
    rv = im_req && mem_busy && (wl == 0);
    if (mem_busy && !rv) wl--;
    im_rvalid = rv;
    im_rdata  = rv ? inst_of(im_addr) : $urandom;
    case (knob_bt)
      1:       begin bt = (im_addr == 32'h8); btgt = 32'h100; end
      2:       begin bt = ($urandom_range(0, 3) == 0);
                     btgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : rnd_pc(); end
      default: begin bt = 1'b0; btgt = rnd_pc(); end
    endcase
    bp_taken = bt; bp_target = btgt;
    rd    = frd || (knob_rdrand && ($urandom_range(0, 15) == 0));
    rd_pc = frd ? fpc : rnd_pc();
    redirect_valid = rd; redirect_pc = rd_pc;
    rdy = (knob_rdy == 2) ? bit'($urandom_range(0, 1)) : (knob_rdy == 1);
    id_ready = rdy;
    #1;
    addr_log.push_back(im_addr); req_log.push_back(im_req); done_log.push_back(if_done);
    vld_log.push_back(id_valid); idpc_log.push_back(id_pc); ptk_log.push_back(id_ptaken);
    ptg_log.push_back(id_ptarget); pf_log.push_back(perf_fetch_cnt); pr_log.push_back(perf_redirect_cnt);

    req_on   = (q.size() < 2);
    exp_done = req_on && rv && !doomed && !rd;
    chk("im_req", {31'd0, im_req}, {31'd0, req_on});
    chk("im_addr", im_addr, exp_addr);
    chk("bp_pc", bp_pc, exp_addr);
    chk("if_done", {31'd0, if_done}, {31'd0, exp_done});
    chk("id_valid", {31'd0, id_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("id_inst", id_inst, q[0].inst);
      chk("id_pc", id_pc, q[0].pc);
      chk("id_ptarget", id_ptarget, q[0].tgt);
      chk("id_ptaken", {31'd0, id_ptaken}, {31'd0, q[0].tk});
    end
`ifdef IFU_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, exp_fc);
    chk("perf_redir", perf_redirect_cnt, exp_rc);
`else
    chk("perf_fetch", perf_fetch_cnt, 32'h0);
    chk("perf_redir", perf_redirect_cnt, 32'h0);
`endif

    if (exp_done) exp_fc++;
    if (rd) exp_rc++;
    consume = (q.size() > 0) && rdy;
    if (rd) begin
      q.delete();
      if (!req_on || rv) begin
        exp_addr = rd_pc;
        doomed   = 1'b0;
      end else begin
        doomed  = 1'b1;
        doom_pc = rd_pc;
      end
    end else begin
      if (consume) void'(q.pop_front());
      if (req_on && rv) begin
        if (doomed) begin
          exp_addr = doom_pc;
          doomed   = 1'b0;
        end else begin
          q.push_back('{inst: inst_of(exp_addr), pc: exp_addr, tgt: btgt, tk: bt});
          exp_addr = bt ? btgt : exp_addr + 32'd4;
        end
      end
    end
    if (rv) mem_busy = 1'b0;
  endtask

  initial begin
    knob_w = 0; knob_wrand = 1'b0; knob_rdy = 1; knob_bt = 1; knob_rdrand = 1'b0;
    do_reset();

    // Zero-wait streaming with a taken prediction at 0x8.
    clear_logs();
    repeat (6) cycle(1'b0, 32'h0);
    chk("seq_addr0", addr_log[0], 32'h0);
    chk("seq_addr1", addr_log[1], 32'h4);
    chk("seq_addr2", addr_log[2], 32'h8);
    chk("seq_addr3", addr_log[3], 32'h100);
    chk("seq_addr4", addr_log[4], 32'h104);
    chk("seq_idpc1", idpc_log[1], 32'h0);
    chk("seq_idpc2", idpc_log[2], 32'h4);
    chk("bt_idpc", idpc_log[3], 32'h8);
    chk("bt_ptaken", {31'd0, ptk_log[3]}, 32'd1);
    chk("bt_ptarget", ptg_log[3], 32'h100);
    chk("seq_done0", {31'd0, done_log[0]}, 32'd1);

    // Three cycles of backpressure fill output and hold entries.
    clear_logs();
    knob_rdy = 0;
    repeat (3) cycle(1'b0, 32'h0);
    knob_rdy = 1;
    repeat (4) cycle(1'b0, 32'h0);
    chk("stall_req0", {31'd0, req_log[0]}, 32'd1);
    chk("stall_req1", {31'd0, req_log[1]}, 32'd0);
    chk("stall_req3", {31'd0, req_log[3]}, 32'd0);
    chk("stall_req4", {31'd0, req_log[4]}, 32'd1);
    chk("stall_order", idpc_log[4], idpc_log[3] + 32'd4);

    // Redirect while a 3-wait request is in flight, then two redirects during the drop.
    cycle(1'b1, 32'h10);
    clear_logs();
    knob_w = 3;
    cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h200);
    repeat (3) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h300);
    cycle(1'b1, 32'h400);
    repeat (2) cycle(1'b0, 32'h0);
    chk("drop_addr1", addr_log[1], 32'h10);
    chk("drop_addr3", addr_log[3], 32'h10);
    chk("drop_done3", {31'd0, done_log[3]}, 32'd0);
    chk("drop_vld3", {31'd0, vld_log[3]}, 32'd0);
    chk("drop_addr4", addr_log[4], 32'h200);
    chk("drop_vld4", {31'd0, vld_log[4]}, 32'd0);
    chk("drop2_addr7", addr_log[7], 32'h200);
    chk("drop2_addr8", addr_log[8], 32'h400);

    // Randomized traffic.
    knob_w = 2; knob_wrand = 1'b1; knob_rdy = 2; knob_bt = 2; knob_rdrand = 1'b1;
    clear_logs();
    repeat (3000) cycle(1'b0, 32'h0);

    // Reset with a request outstanding.
    knob_w = 3; knob_wrand = 1'b0; knob_rdy = 1; knob_bt = 0; knob_rdrand = 1'b0;
    for (int i = 0; i < 20 && !(mem_busy && wl > 0); i++) cycle(1'b0, 32'h0);
    chk("midreq_busy", {31'd0, mem_busy}, 32'd1);
    do_reset();

    // Counter scenario: ten accepted fetches, two redirects whose responses are discarded.
    knob_w = 0;
    clear_logs();
    repeat (10) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h40);
    cycle(1'b1, 32'h80);
    cycle(1'b0, 32'h0);
    chk("perf_addr_after", addr_log[12], 32'h80);
`ifdef IFU_PERF_EN
    chk("perf_fetch_10", pf_log[12], 32'd10);
    chk("perf_redir_2", pr_log[12], 32'd2);
`else
    chk("perf_fetch_off", pf_log[12], 32'd0);
    chk("perf_redir_off", pr_log[12], 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
